intf_unit: RTL and testbench
============================

INTF_UNIT -- requirements
Module: intf_unit

Interface
REQ-001 The parameter PARAM SHALL default to 0; it is an instance identifier reported on param_out.
REQ-002 The parameter N_ELEM SHALL default to 2; it sets the number of val elements, and legal values are 1..256.
REQ-003 The parameter FUNC_VAL SHALL default to 5; it is the constant returned by the function query.
REQ-004 The derived constant IDX_W SHALL equal max(1, clog2(N_ELEM)).
REQ-005 Port clk: input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 Port rst_n: input, 1 bit, reset; it is asynchronous and active-low.
REQ-007 Port wr_en: input, 1 bit, write strobe for one element.
REQ-008 Port wr_idx: input, IDX_W bits, index of the element to write.
REQ-009 Port wr_val: input, 1 bit, value to write.
REQ-010 Port set_all: input, 1 bit, drives every element to 1.
REQ-011 Port rd_idx: input, IDX_W bits, read index.
REQ-012 Port rd_val: output, 1 bit, value of the element at rd_idx.
REQ-013 Port val_vec: output, N_ELEM bits, all element values; bit i is element i.
REQ-014 Port all_set: output, 1 bit, high when every element is 1.
REQ-015 Port func_req: input, 1 bit, function-query request.
REQ-016 Port func_ack: output, 1 bit, function-query acknowledge.
REQ-017 Port func_data: output, 32 bits, function-query result.
REQ-018 Port param_out: output, 32 bits, PARAM zero-extended, constant.

Function
REQ-019 Each element SHALL be a 1-bit register; val_vec SHALL drive all registers directly, with no added latency.
REQ-020 When wr_en=1 and wr_idx<N_ELEM, element[wr_idx] SHALL take wr_val on the next rising edge.
REQ-021 When wr_en=1 and wr_idx>=N_ELEM, the write SHALL be ignored with no state change.
REQ-022 When set_all=1, every element SHALL become 1 on the next edge.
REQ-023 When set_all=1 and a legal wr_en occur in the same cycle, set_all SHALL apply first and the write SHALL then override the addressed element.
REQ-024 rd_val SHALL be combinational: element[rd_idx] when rd_idx<N_ELEM, else 0.
REQ-025 all_set SHALL be the combinational AND-reduction of val_vec.
REQ-026 func_ack SHALL be func_req registered, giving a latency of 1 cycle.
REQ-027 func_data SHALL be FUNC_VAL (32-bit) when func_ack=1, else 0.
REQ-028 A func_req held high SHALL yield func_ack on every cycle, one cycle delayed, with no handshake stall.
REQ-029 param_out SHALL equal PARAM at all times, including during reset.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately clear all elements, func_ack and func_data to 0, independent of clk.
REQ-031 While rst_n=0, val_vec SHALL be 0, rd_val SHALL be 0 and all_set SHALL be 0 (N_ELEM>=1).
REQ-032 Reset asserted mid-query SHALL drop a pending ack; after release, the first ack SHALL come from a func_req sampled after release.
REQ-033 Writes sampled on the edge coincident with reset release SHALL be ignored; writes take effect from the first edge with rst_n=1.

Structure
REQ-034 A shared package intf_unit_pkg SHALL hold the FUNC_VAL default (5), the 32-bit data width constant, and the clog2-based index-width helper.
REQ-035 The element register bank SHALL be one sub-module, intf_unit_bank, containing the storage, write decode, set_all logic and read mux; the query and parameter logic SHALL sit in the top level.
REQ-036 The design SHALL contain no latches, and all state SHALL be in one clocked domain.

Verification
REQ-037 Reset then idle: val_vec=2'b00, all_set=0, func_ack=0, func_data=0, param_out=PARAM.
REQ-038 Writes: wr_idx=0, wr_val=1, then wr_idx=1, wr_val=1 -> val_vec=2'b11 and all_set=1 one cycle after the second write; rd_idx=1 -> rd_val=1.
REQ-039 Out-of-range write: N_ELEM=3, wr_idx=3, wr_val=1 -> val_vec unchanged; rd_idx=3 -> rd_val=0.
REQ-040 Simultaneous operations: set_all=1 with wr_en=1, wr_idx=0, wr_val=0 -> val_vec=2'b10 next cycle.
REQ-041 Function query: a 3-cycle func_req pulse -> 3 cycles of func_ack with func_data=5, delayed 1 cycle; with FUNC_VAL=9 -> func_data=9.
REQ-042 Mid-operation reset: rst_n pulsed low between clock edges while func_req=1 and val_vec=2'b11 -> all outputs clear immediately; PARAM=1 instance -> param_out=1 throughout.

Source files
------------

// File: rtl/intf_unit_pkg.sv
// Shared constants and helpers for the intf_unit element bank and query logic.
package intf_unit_pkg;

  // Width of the query result and parameter report buses.
  localparam int unsigned DATA_W = 32;

  // Constant returned by the function query unless overridden per instance.
  localparam int unsigned FUNC_VAL_DEFAULT = 5;

  // Index width for a bank of n elements; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intf_unit_bank.sv
// Bank of single-bit element registers with indexed write, broadcast set and
// indexed combinational read.
module intf_unit_bank
  import intf_unit_pkg::*;
#(
  parameter int unsigned N_ELEM = 2,
  localparam int unsigned IDX_W = idx_width(N_ELEM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_val,
  input  logic             set_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_val,
  output logic [N_ELEM-1:0] val_vec
);

  logic [N_ELEM-1:0] vals;

  // Element storage: set_all fills the bank, then a legal write overrides its
  // element; indices at or beyond N_ELEM never match the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vals <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ELEM; i++) begin
        if (wr_en && (32'(wr_idx) == i)) begin
          vals[i] <= wr_val;
        end else if (set_all) begin
          vals[i] <= 1'b1;
        end
      end
    end
  end

  // Read mux: out-of-range indices read as 0.
  always_comb begin
    rd_val = 1'b0;
    for (int unsigned i = 0; i < N_ELEM; i++) begin
      if (32'(rd_idx) == i) begin
        rd_val = vals[i];
      end
    end
  end

  assign val_vec = vals;

endmodule

// File: rtl/intf_unit.sv
// intf_unit: element register bank plus a fixed-latency constant query port
// and a constant instance identifier.
module intf_unit
  import intf_unit_pkg::*;
#(
  parameter int unsigned PARAM    = 0,
  parameter int unsigned N_ELEM   = 2,
  parameter int unsigned FUNC_VAL = FUNC_VAL_DEFAULT,
  localparam int unsigned IDX_W   = idx_width(N_ELEM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_val,
  input  logic              set_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_val,
  output logic [N_ELEM-1:0] val_vec,
  output logic              all_set,
  input  logic              func_req,
  output logic              func_ack,
  output logic [DATA_W-1:0] func_data,
  output logic [DATA_W-1:0] param_out
);

  intf_unit_bank #(
    .N_ELEM (N_ELEM)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_val  (wr_val),
    .set_all (set_all),
    .rd_idx  (rd_idx),
    .rd_val  (rd_val),
    .val_vec (val_vec)
  );

  // Query acknowledge: request delayed by one cycle, no stall on held requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_ack <= 1'b0;
    end else begin
      func_ack <= func_req;
    end
  end

  // Result qualified by the ack so it clears together with it on reset.
  always_comb begin
    func_data = '0;
    if (func_ack) begin
      func_data = DATA_W'(FUNC_VAL);
    end
  end

  assign all_set   = &val_vec;
  assign param_out = DATA_W'(PARAM);

endmodule

// File: tb/tb_intf_unit.sv
// Bench for intf_unit: a default instance and a PARAM=1/N_ELEM=3/FUNC_VAL=9
// instance share stimulus; an array model is compared every cycle and
// hand-computed literals pin the model.
module tb_intf_unit;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic       wr_val;
  logic       set_all;
  logic [1:0] rd_idx;
  logic       func_req;

  logic        rd_val0, all_set0, func_ack0;
  logic [1:0]  val_vec0;
  logic [31:0] func_data0, param_out0;
  logic        rd_val1, all_set1, func_ack1;
  logic [2:0]  val_vec1;
  logic [31:0] func_data1, param_out1;

  int checks   = 0;
  int failures = 0;

  intf_unit u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx[0:0]),
    .wr_val    (wr_val),
    .set_all   (set_all),
    .rd_idx    (rd_idx[0:0]),
    .rd_val    (rd_val0),
    .val_vec   (val_vec0),
    .all_set   (all_set0),
    .func_req  (func_req),
    .func_ack  (func_ack0),
    .func_data (func_data0),
    .param_out (param_out0)
  );

  intf_unit #(
    .PARAM    (1),
    .N_ELEM   (3),
    .FUNC_VAL (9)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_val    (wr_val),
    .set_all   (set_all),
    .rd_idx    (rd_idx),
    .rd_val    (rd_val1),
    .val_vec   (val_vec1),
    .all_set   (all_set1),
    .func_req  (func_req),
    .func_ack  (func_ack1),
    .func_data (func_data1),
    .param_out (param_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: element arrays per instance (dut0 only sees index bit 0) and the
  // ack as the request seen on the previous edge.
  bit m0 [2] = '{0, 0};
  bit m1 [3] = '{0, 0, 0};
  bit ack_m  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m0[i] <= 0;
      for (int i = 0; i < 3; i++) m1[i] <= 0;
      ack_m <= 0;
    end else begin
      ack_m <= func_req;
      if (set_all) begin
        for (int i = 0; i < 2; i++) m0[i] <= 1;
        for (int i = 0; i < 3; i++) m1[i] <= 1;
      end
      if (wr_en) begin
        m0[int'(wr_idx[0])] <= wr_val;
        if (int'(wr_idx) < 3) m1[int'(wr_idx)] <= wr_val;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0] ev0;
    logic [2:0] ev1;
    logic       er1;
    ev0 = {m0[1], m0[0]};
    ev1 = {m1[2], m1[1], m1[0]};
    er1 = (int'(rd_idx) < 3) ? m1[int'(rd_idx)] : 1'b0;
    chk("m_val_vec0",  32'(val_vec0), 32'(ev0));
    chk("m_all_set0",  32'(all_set0), 32'(ev0 == 2'b11));
    chk("m_rd_val0",   32'(rd_val0),  32'(m0[int'(rd_idx[0])]));
    chk("m_val_vec1",  32'(val_vec1), 32'(ev1));
    chk("m_all_set1",  32'(all_set1), 32'(ev1 == 3'b111));
    chk("m_rd_val1",   32'(rd_val1),  32'(er1));
    chk("m_func_ack0", 32'(func_ack0), 32'(ack_m));
    chk("m_func_ack1", 32'(func_ack1), 32'(ack_m));
    chk("m_func_data0", func_data0, ack_m ? 32'd5 : 32'd0);
    chk("m_func_data1", func_data1, ack_m ? 32'd9 : 32'd0);
    chk("m_param_out0", param_out0, 32'd0);
    chk("m_param_out1", param_out1, 32'd1);
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_val = 1'b0;
    set_all = 1'b0; rd_idx = '0; func_req = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_val_vec0", 32'(val_vec0), 32'd0);
    chk("rst_all_set0", 32'(all_set0), 32'd0);
    chk("rst_rd_val0",  32'(rd_val0),  32'd0);
    chk("rst_param1",   param_out1,    32'd1);
    rst_n = 1'b1;
    cyc();
    chk("idle_val_vec0", 32'(val_vec0), 32'd0);
    chk("idle_all_set0", 32'(all_set0), 32'd0);
    chk("idle_ack0",     32'(func_ack0), 32'd0);
    chk("idle_data0",    func_data0,     32'd0);
    chk("idle_param0",   param_out0,     32'd0);

    // Two writes fill the default bank.
    wr_en = 1'b1; wr_idx = 2'd0; wr_val = 1'b1;
    cyc();
    wr_idx = 2'd1;
    cyc();
    wr_en = 1'b0; rd_idx = 2'd1;
    #1;
    chk("wr_val_vec0", 32'(val_vec0), 32'b11);
    chk("wr_all_set0", 32'(all_set0), 32'd1);
    chk("wr_rd_val0",  32'(rd_val0),  32'd1);
    chk("wr_val_vec1", 32'(val_vec1), 32'b011);
    chk("wr_all_set1", 32'(all_set1), 32'd0);

    // Out-of-range write on the 3-element instance.
    wr_en = 1'b1; wr_idx = 2'd3; wr_val = 1'b1;
    cyc();
    wr_en = 1'b0; rd_idx = 2'd3;
    #1;
    chk("oor_val_vec1", 32'(val_vec1), 32'b011);
    chk("oor_rd_val1",  32'(rd_val1),  32'd0);

    // set_all with a same-cycle write of 0 to element 0.
    set_all = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_val = 1'b0;
    cyc();
    set_all = 1'b0; wr_en = 1'b0; rd_idx = 2'd0;
    #1;
    chk("sim_val_vec0", 32'(val_vec0), 32'b10);
    chk("sim_val_vec1", 32'(val_vec1), 32'b110);
    chk("sim_rd_val0",  32'(rd_val0),  32'd0);

    // Three-cycle query pulse.
    func_req = 1'b1;
    #1;
    chk("q_pre_ack0", 32'(func_ack0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) func_req = 1'b0;
      chk("q_ack0",  32'(func_ack0), 32'd1);
      chk("q_data0", func_data0,     32'd5);
      chk("q_data1", func_data1,     32'd9);
    end
    cyc();
    chk("q_post_ack0",  32'(func_ack0), 32'd0);
    chk("q_post_data1", func_data1,     32'd0);

    // Reset pulse between edges with a full bank and a live query.
    set_all = 1'b1;
    cyc();
    set_all = 1'b0; func_req = 1'b1;
    cyc();
    chk("mr_pre_vec0", 32'(val_vec0), 32'b11);
    chk("mr_pre_ack0", 32'(func_ack0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_val_vec0", 32'(val_vec0), 32'd0);
    chk("mr_val_vec1", 32'(val_vec1), 32'd0);
    chk("mr_all_set0", 32'(all_set0), 32'd0);
    chk("mr_rd_val0",  32'(rd_val0),  32'd0);
    chk("mr_ack0",     32'(func_ack0), 32'd0);
    chk("mr_data1",    func_data1,     32'd0);
    chk("mr_param1",   param_out1,     32'd1);
    rst_n = 1'b1;
    cyc();
    chk("mr_ack_after", 32'(func_ack0), 32'd1);

    // Request dropped during reset yields no ack after release.
    #1 rst_n = 1'b0; func_req = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    chk("mr_noack0", 32'(func_ack0), 32'd0);
    chk("mr_nodata0", func_data0,    32'd0);

    // Write presented across a reset edge takes effect only once released.
    rst_n = 1'b0; wr_en = 1'b1; wr_idx = 2'd0; wr_val = 1'b1;
    cyc();
    chk("rw_held_vec0", 32'(val_vec0), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rw_vec0", 32'(val_vec0), 32'b01);
    chk("rw_vec1", 32'(val_vec1), 32'b001);
    wr_en = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
